balance_pid: RTL and testbench

Closed-loop balance controller that sits directly downstream of the angle sensor-fusion stage. It takes each new filtered angle, runs a saturating fixed-point PID against a setpoint, and drives a sign/magnitude PWM to the motor H-bridge. It owns the only clocked arithmetic between the IMU path and the drive stage. Its fall detection cuts motor drive when the vehicle is down.

---
 rtl/balance_pkg.sv | 46 ++++
 rtl/motor_pwm.sv | 41 ++++
 rtl/balance_pid.sv | 224 ++++++++++++++++++++++
 tb/tb_balance_pid.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/balance_pkg.sv
// Shared types, widths and saturating helpers for the balance controller.
package balance_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC_P = 3'd1,
        ST_CALC_I = 3'd2,
        ST_CALC_D = 3'd3,
        ST_SUM    = 3'd4
    } pid_state_e;

    localparam int ANG_W  = 10;
    localparam int CMD_W  = 10;
    localparam int ERR_W  = 11;
    localparam int DER_W  = 12;
    localparam int INT_W  = 16;
    localparam int PROD_W = 24;
    localparam int SUM_W  = 26;

    // Clamp a one-bit-wider integrator sum back into +/-lim.
    function automatic logic signed [INT_W-1:0] clamp_int(
        input logic signed [INT_W:0] v,
        input logic signed [INT_W:0] lim
    );
        if (v > lim)
            clamp_int = INT_W'(lim);
        else if (v < -lim)
            clamp_int = INT_W'(-lim);
        else
            clamp_int = INT_W'(v);
    endfunction

    // Saturate the shifted PID sum to the +/-lim command range.
    function automatic logic signed [CMD_W-1:0] saturate_cmd(
        input logic signed [SUM_W-1:0] v,
        input logic signed [SUM_W-1:0] lim
    );
        if (v > lim)
            saturate_cmd = CMD_W'(lim);
        else if (v < -lim)
            saturate_cmd = CMD_W'(-lim);
        else
            saturate_cmd = CMD_W'(v);
    endfunction

endpackage

// File: rtl/motor_pwm.sv
// Sign/magnitude PWM: free-running 8-bit counter, duty and direction
// latched only on the 255->0 wrap so a period is never cut short.
module motor_pwm
    import balance_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [CMD_W-1:0] command,
    output logic                    pwm,
    output logic                    dir
);

    logic [7:0]       cnt;
    logic [7:0]       duty;
    logic             dir_q;
    logic [CMD_W-1:0] mag;

    // Magnitude of the command; anything above 255 pins to full duty.
    always_comb begin
        mag = command[CMD_W-1] ? $unsigned(-command) : $unsigned(command);
    end

    // Counter plus wrap-synchronous latch of duty and direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= 8'd0;
            duty  <= 8'd0;
            dir_q <= 1'b0;
        end else begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'hFF) begin
                duty  <= (mag > CMD_W'(255)) ? 8'hFF : mag[7:0];
                dir_q <= command[CMD_W-1];
            end
        end
    end

    assign pwm = (cnt < duty);
    assign dir = dir_q;

endmodule

// File: rtl/balance_pid.sv
// Balance controller: synchronised DataReady edge starts a 4-step PID
// (P, I, D products on one shared multiplier, then sum/saturate), with
// fall-over detection and a sign/magnitude PWM output stage.
//
// Output handshake: CmdValid is a one-cycle pulse; Command is valid in
// that cycle and holds until the next pulse. There is no back-pressure.
module balance_pid
    import balance_pkg::*;
#(
    parameter int KP            = 12,
    parameter int KI            = 1,
    parameter int KD            = 20,
    parameter int SHIFT         = 4,
    parameter int INT_LIMIT     = 2000,
    parameter int MAX_DUTY      = 255,
    parameter int FALL_LIMIT    = 200,
    parameter int RECOVER_LIMIT = 150
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    DataReady,
    input  logic signed [ANG_W-1:0] Angle,
    input  logic signed [ANG_W-1:0] Setpoint,
    input  logic                    Enable,
    output logic signed [CMD_W-1:0] Command,
    output logic                    CmdValid,
    output logic                    Fallen,
    output logic                    MotorPwm,
    output logic                    MotorDir,
    output pid_state_e              fsm_state
);

    localparam logic signed [INT_W:0]    INT_LIM_S = (INT_W+1)'(INT_LIMIT);
    localparam logic signed [SUM_W-1:0]  MAX_S     = SUM_W'(MAX_DUTY);
    localparam logic [ANG_W:0]           FALL_U    = (ANG_W+1)'(FALL_LIMIT);
    localparam logic [ANG_W:0]           REC_U     = (ANG_W+1)'(RECOVER_LIMIT);
    localparam logic signed [PROD_W-1:0] KP_X      = PROD_W'(KP);
    localparam logic signed [PROD_W-1:0] KI_X      = PROD_W'(KI);
    localparam logic signed [PROD_W-1:0] KD_X      = PROD_W'(KD);

    logic dr_s1, dr_s2, dr_s3, rise;
    logic pending, start;
    logic ld_p, ld_i, ld_d, do_sum;
    pid_state_e state, state_nxt;

    logic signed [ANG_W-1:0]  ang_q, sp_q;
    logic signed [ERR_W-1:0]  error, prev_err;
    logic signed [DER_W-1:0]  deriv;
    logic signed [INT_W-1:0]  integ, integ_nxt;
    logic signed [INT_W:0]    int_sum;
    logic signed [PROD_W-1:0] mul_a, mul_g, product, p_q, i_q, d_q;
    logic signed [SUM_W-1:0]  sum, shifted;
    logic signed [CMD_W-1:0]  sat_cmd, command_q;
    logic signed [ANG_W:0]    ang_x;
    logic [ANG_W:0]           abs_ang;
    logic                     fallen_q, fallen_nxt, force_zero, cmd_valid_q;

    // Two-flop synchroniser for the asynchronous strobe, plus edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dr_s1 <= 1'b0;
            dr_s2 <= 1'b0;
            dr_s3 <= 1'b0;
        end else begin
            dr_s1 <= DataReady;
            dr_s2 <= dr_s1;
            dr_s3 <= dr_s2;
        end
    end

    assign rise = dr_s2 & ~dr_s3;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: one step per cycle once a sample is started.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CALC_P;
            ST_CALC_P: state_nxt = ST_CALC_I;
            ST_CALC_I: state_nxt = ST_CALC_D;
            ST_CALC_D: state_nxt = ST_SUM;
            ST_SUM:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: sample start and per-state load strobes.
    always_comb begin
        start  = (state == ST_IDLE) && (rise || pending);
        ld_p   = (state == ST_CALC_P);
        ld_i   = (state == ST_CALC_I);
        ld_d   = (state == ST_CALC_D);
        do_sum = (state == ST_SUM);
    end

    assign fsm_state = state;

    // One-deep pending flag for an edge seen while busy; extra edges drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= 1'b0;
        else if (start)
            pending <= 1'b0;
        else if (rise)
            pending <= 1'b1;
    end

    // Capture the sample operands when a calculation starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ang_q <= '0;
            sp_q  <= '0;
        end else if (start) begin
            ang_q <= Angle;
            sp_q  <= Setpoint;
        end
    end

    // Error, derivative, integrator update and fall decision.
    always_comb begin
        error      = {sp_q[ANG_W-1], sp_q} - {ang_q[ANG_W-1], ang_q};
        deriv      = {error[ERR_W-1], error} - {prev_err[ERR_W-1], prev_err};
        int_sum    = {{(INT_W+1-ERR_W){error[ERR_W-1]}}, error} + {integ[INT_W-1], integ};
        integ_nxt  = clamp_int(int_sum, INT_LIM_S);
        ang_x      = {ang_q[ANG_W-1], ang_q};
        abs_ang    = ang_x[ANG_W] ? $unsigned(-ang_x) : $unsigned(ang_x);
        fallen_nxt = fallen_q;
        if (abs_ang > FALL_U)
            fallen_nxt = 1'b1;
        else if (abs_ang <= REC_U)
            fallen_nxt = 1'b0;
        force_zero = fallen_nxt | ~Enable;
    end

    // Shared multiplier: operand and gain selected by the current state.
    always_comb begin
        mul_a = '0;
        mul_g = '0;
        case (state)
            ST_CALC_P: begin
                mul_a = {{(PROD_W-ERR_W){error[ERR_W-1]}}, error};
                mul_g = KP_X;
            end
            ST_CALC_I: begin
                mul_a = {{(PROD_W-INT_W){integ[INT_W-1]}}, integ};
                mul_g = KI_X;
            end
            ST_CALC_D: begin
                mul_a = {{(PROD_W-DER_W){deriv[DER_W-1]}}, deriv};
                mul_g = KD_X;
            end
            default: begin
                mul_a = '0;
                mul_g = '0;
            end
        endcase
        product = mul_a * mul_g;
    end

    // Sum of terms, floor shift, then saturate to the duty range.
    always_comb begin
        sum     = {{(SUM_W-PROD_W){p_q[PROD_W-1]}}, p_q}
                + {{(SUM_W-PROD_W){i_q[PROD_W-1]}}, i_q}
                + {{(SUM_W-PROD_W){d_q[PROD_W-1]}}, d_q};
        shifted = sum >>> SHIFT;
        sat_cmd = saturate_cmd(shifted, MAX_S);
    end

    // Controller state and registered outputs, stepped by the FSM strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q         <= '0;
            i_q         <= '0;
            d_q         <= '0;
            integ       <= '0;
            prev_err    <= '0;
            command_q   <= '0;
            cmd_valid_q <= 1'b0;
            fallen_q    <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (ld_p) begin
                p_q   <= product;
                integ <= integ_nxt;
            end
            if (ld_i)
                i_q <= product;
            if (ld_d)
                d_q <= product;
            if (do_sum) begin
                cmd_valid_q <= 1'b1;
                fallen_q    <= fallen_nxt;
                if (force_zero) begin
                    command_q <= '0;
                    integ     <= '0;
                    prev_err  <= '0;
                end else begin
                    command_q <= sat_cmd;
                    prev_err  <= error;
                end
            end
        end
    end

    assign Command  = command_q;
    assign CmdValid = cmd_valid_q;
    assign Fallen   = fallen_q;

    motor_pwm u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .command (command_q),
        .pwm     (MotorPwm),
        .dir     (MotorDir)
    );

endmodule

// File: tb/tb_balance_pid.sv
// Bench for balance_pid: vector table with a command scoreboard, plus
// hand sequences for saturation, integrator clamp, PWM duty, edge
// pile-up and mid-calculation reset.
module tb_balance_pid;
    import balance_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    DataReady;
    logic signed [ANG_W-1:0] Angle;
    logic signed [ANG_W-1:0] Setpoint;
    logic                    Enable;
    logic signed [CMD_W-1:0] Command;
    logic                    CmdValid;
    logic                    Fallen;
    logic                    MotorPwm;
    logic                    MotorDir;
    pid_state_e              fsm_state;

    balance_pid dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .DataReady (DataReady),
        .Angle     (Angle),
        .Setpoint  (Setpoint),
        .Enable    (Enable),
        .Command   (Command),
        .CmdValid  (CmdValid),
        .Fallen    (Fallen),
        .MotorPwm  (MotorPwm),
        .MotorDir  (MotorDir),
        .fsm_state (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests_run    = 0;
    int tests_failed = 0;

    // scoreboard: {fallen, command}
    logic [CMD_W:0] exp_q[$];
    int valid_count    = 0;
    int last_valid_cyc = -100;
    int prev_valid_cyc = -100;

    typedef struct {
        int   angle;
        int   setpoint;
        logic enable;
        int   cmd;
        logic fallen;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // monitor: pop and compare on every CmdValid
    always @(negedge clk) begin
        logic [CMD_W:0] e;
        if (reset_n && CmdValid) begin
            check("cmdvalid_gap", int'((cyc - last_valid_cyc) > 1), 1);
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            valid_count++;
            check("expected_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("command", int'(Command), int'($signed(e[CMD_W-1:0])));
                check("fallen", int'(Fallen), int'(e[CMD_W]));
            end
        end
    end

    function automatic int model_cmd(input int s);
        int q;
        if (s >= 0) q = s / 16;
        else        q = -((-s + 15) / 16);
        if (q > 255)  q = 255;
        if (q < -255) q = -255;
        return q;
    endfunction

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        reset_n   = 1'b0;
        DataReady = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input int a, input int sp, input logic en, input int ec, input logic ef);
        int t0, n0, lat;
        logic [CMD_W:0] e;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        Angle    = a[ANG_W-1:0];
        Setpoint = sp[ANG_W-1:0];
        Enable   = en;
        e = {ef, ec[CMD_W-1:0]};
        exp_q.push_back(e);
        t0 = cyc;
        n0 = valid_count;
        DataReady = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        DataReady = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid_count != n0) break;
            @(posedge clk);
        end
        check("cmdvalid_seen", valid_count - n0, 1);
        if (valid_count != n0) begin
            lat = last_valid_cyc - t0;
            check("latency_7_to_8", int'(lat >= 7 && lat <= 8), 1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic count_pwm(output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (MotorPwm) hi++;
        end
    endtask

    task automatic wait_dir(input logic want);
        int k;
        k = 0;
        while (MotorDir !== want && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("motordir_latched", int'(MotorDir), int'(want));
    endtask

    // watchdog
    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int hi, n0, integ_m, d_m, sum_m, t_first;

        vecs[0]  = '{10,    0, 1'b1, -21,  1'b0};
        vecs[1]  = '{-10,   0, 1'b1, 32,   1'b0};
        vecs[2]  = '{5,     5, 1'b1, -13,  1'b0};
        vecs[3]  = '{-150,  0, 1'b1, 255,  1'b0};
        vecs[4]  = '{0,     0, 1'b0, 0,    1'b0};
        vecs[5]  = '{1,     0, 1'b1, -3,   1'b0};
        vecs[6]  = '{0,    20, 1'b1, 42,   1'b0};
        vecs[7]  = '{210,   0, 1'b1, 0,    1'b1};
        vecs[8]  = '{170,   0, 1'b1, 0,    1'b1};
        vecs[9]  = '{-201,  0, 1'b1, 0,    1'b1};
        vecs[10] = '{140,   0, 1'b1, -255, 1'b0};
        vecs[11] = '{150,   0, 1'b1, -144, 1'b0};
        vecs[12] = '{0,     0, 1'b1, 169,  1'b0};
        vecs[13] = '{-150, 150, 1'b1, 255, 1'b0};
        vecs[14] = '{180,   0, 1'b1, -255, 1'b0};

        reset_n   = 1'b0;
        DataReady = 1'b0;
        Angle     = '0;
        Setpoint  = '0;
        Enable    = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_command", int'(Command), 0);
        check("rst_cmdvalid", int'(CmdValid), 0);
        check("rst_fallen", int'(Fallen), 0);
        check("rst_pwm", int'(MotorPwm), 0);
        check("rst_dir", int'(MotorDir), 0);
        check("rst_state", int'(fsm_state), int'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // first sample after reset and its PWM shape
        send(10, 0, 1'b1, -21, 1'b0);
        wait_dir(1'b1);
        count_pwm(hi);
        check("pwm_high_21", hi, 21);

        // vector table
        do_reset();
        foreach (vecs[i])
            send(vecs[i].angle, vecs[i].setpoint, vecs[i].enable, vecs[i].cmd, vecs[i].fallen);
        repeat (260) @(negedge clk);
        count_pwm(hi);
        check("pwm_high_255", hi, 255);
        check("pwm_dir_neg", int'(MotorDir), 1);
        send(210, 0, 1'b1, 0, 1'b1);
        repeat (260) @(negedge clk);
        count_pwm(hi);
        check("pwm_high_fallen", hi, 0);

        // saturation on first large error
        do_reset();
        send(150, 0, 1'b1, -255, 1'b0);

        // integrator clamp: 25 samples of Angle 100, then two at 0
        do_reset();
        for (int n = 1; n <= 25; n++) begin
            integ_m = -100 * n;
            if (integ_m < -2000) integ_m = -2000;
            d_m   = (n == 1) ? -2000 : 0;
            sum_m = 12 * (-100) + integ_m + d_m;
            send(100, 0, 1'b1, model_cmd(sum_m), 1'b0);
        end
        send(0, 0, 1'b1, 0, 1'b0);
        send(0, 0, 1'b1, -125, 1'b0);

        // three edges 2 cycles apart: two results, third dropped
        do_reset();
        Angle    = 10'sd10;
        Setpoint = 10'sd0;
        Enable   = 1'b1;
        exp_q.push_back({1'b0, 10'h3EB});   // -21
        exp_q.push_back({1'b0, 10'h3F7});   // -9
        n0 = valid_count;
        t_first = cyc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) DataReady = 1'b1;
            @(negedge clk) DataReady = 1'b0;
        end
        repeat (40) @(negedge clk);
        check("pileup_count", valid_count - n0, 2);
        check("pileup_spacing", last_valid_cyc - prev_valid_cyc, 5);
        check("pileup_first_latency", int'(prev_valid_cyc - t_first <= 8), 1);

        // reset during CALC_I aborts the sample
        do_reset();
        send(10, 0, 1'b1, -21, 1'b0);
        wait_dir(1'b1);
        @(negedge clk) DataReady = 1'b1;
        @(negedge clk) DataReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fsm_state == ST_CALC_I) break;
            @(negedge clk);
        end
        check("reached_calc_i", int'(fsm_state), int'(ST_CALC_I));
        n0 = valid_count;
        reset_n = 1'b0;
        #1;
        check("abort_command", int'(Command), 0);
        check("abort_cmdvalid", int'(CmdValid), 0);
        check("abort_pwm", int'(MotorPwm), 0);
        check("abort_dir", int'(MotorDir), 0);
        check("abort_state", int'(fsm_state), int'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_pulse", valid_count - n0, 0);
        check("queue_empty_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
